// File: rtl/data_island_pkg.sv
// Shared constants, state type and BCH step for the HDMI data-island serializer.
package data_island_pkg;

    localparam logic [7:0] BCH_POLY = 8'h83;
    localparam int PACKET_CLOCKS = 32;
    localparam int HEADER_DATA_BITS = 24;
    localparam int SUBPACKET_DATA_BITS = 56;
    localparam int SUBPACKET_COUNT = 4;

    localparam logic [4:0] LAST_CLOCK = 5'(PACKET_CLOCKS - 1);
    localparam logic [4:0] HDR_ECC_FIRST = 5'(HEADER_DATA_BITS);
    localparam logic [4:0] SP_ECC_FIRST = 5'(SUBPACKET_DATA_BITS / 2);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    function automatic logic [7:0] bch_step(input logic [7:0] ecc,
                                            input logic d);
        logic fb;
        fb = d ^ ecc[0];
        return (ecc >> 1) ^ (fb ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_ecc_lfsr.sv
// Running BCH parity for one code; absorbs 1 or 2 bits per clock, lowest bit first.
module bch_ecc_lfsr #(
    parameter int BITS_PER_CLOCK = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [BITS_PER_CLOCK-1:0] data,
    output logic [7:0]                ecc
);
    import data_island_pkg::*;

    logic [7:0] ecc_q;
    logic [7:0] ecc_d;

    // clear and enable together means "first bit of a new packet"
    always_comb begin
        ecc_d = clear ? 8'h00 : ecc_q;
        if (enable) begin
            for (int b = 0; b < BITS_PER_CLOCK; b++) begin
                ecc_d = bch_step(ecc_d, data[b]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ecc_q <= 8'h00;
        end else begin
            ecc_q <= ecc_d;
        end
    end

    assign ecc = ecc_q;

endmodule

// File: rtl/data_island_packet_serializer.sv
// Serializes one header + four subpackets into 32 clocks of TERC4 nibbles,
// inserting BCH parity computed on the fly.
module data_island_packet_serializer (
    input  logic        clock,
    input  logic        reset,
    input  logic        pktValid,
    output logic        pktReady,
    input  logic [23:0] header,
    input  logic [55:0] subpacket0,
    input  logic [55:0] subpacket1,
    input  logic [55:0] subpacket2,
    input  logic [55:0] subpacket3,
    input  logic        hsync,
    input  logic        vsync,
    output logic        islandActive,
    output logic [3:0]  ch0,
    output logic [3:0]  ch1,
    output logic [3:0]  ch2
);
    import data_island_pkg::*;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [23:0]      hdr_q, hdr_d;
    logic [3:0][55:0] sp_q, sp_d;
    logic             ready_q, ready_d;
    logic             active_q, active_d;
    logic [3:0]       ch0_q, ch0_d;
    logic [3:0]       ch1_q, ch1_d;
    logic [3:0]       ch2_q, ch2_d;

    logic             accept;
    logic             advance;
    logic             hdr_bit;
    logic [3:0][1:0]  sp_bits;
    logic [7:0]       hdr_ecc;
    logic [3:0][7:0]  sp_ecc;
    logic [3:0][55:0] sp_in;

    assign sp_in = {subpacket3, subpacket2, subpacket1, subpacket0};
    assign accept = pktValid && ready_q;

    // Data bits are taken straight from the inputs on the accept cycle
    // so that index 0 appears on the very next clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        sp_d    = sp_q;
        advance = 1'b0;
        hdr_bit = hdr_q[0];
        for (int k = 0; k < SUBPACKET_COUNT; k++) begin
            sp_bits[k] = sp_q[k][1:0];
        end
        if (accept) begin
            state_d = ST_ACTIVE;
            cnt_d   = 5'd0;
            advance = 1'b1;
            hdr_bit = header[0];
            hdr_d   = header >> 1;
            for (int k = 0; k < SUBPACKET_COUNT; k++) begin
                sp_bits[k] = sp_in[k][1:0];
                sp_d[k]    = sp_in[k] >> 2;
            end
        end else if (state_q == ST_ACTIVE) begin
            if (cnt_q == LAST_CLOCK) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d   = cnt_q + 5'd1;
                advance = 1'b1;
                hdr_d   = hdr_q >> 1;
                for (int k = 0; k < SUBPACKET_COUNT; k++) begin
                    sp_d[k] = sp_q[k] >> 2;
                end
            end
        end
    end

    bch_ecc_lfsr #(
        .BITS_PER_CLOCK(1)
    ) u_hdr_ecc (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .enable(advance && (cnt_d < HDR_ECC_FIRST)),
        .data  (hdr_bit),
        .ecc   (hdr_ecc)
    );

    for (genvar k = 0; k < SUBPACKET_COUNT; k++) begin : g_sp_ecc
        bch_ecc_lfsr #(
            .BITS_PER_CLOCK(2)
        ) u_sp_ecc (
            .clock (clock),
            .reset (reset),
            .clear (accept),
            .enable(advance && (cnt_d < SP_ECC_FIRST)),
            .data  (sp_bits[k]),
            .ecc   (sp_ecc[k])
        );
    end

    // Parity indices fall out of the low counter bits (24 = 5'b11000, 28 = 5'b11100).
    always_comb begin
        active_d = advance;
        ready_d  = (state_d == ST_IDLE) || (cnt_d == LAST_CLOCK);
        ch0_d    = {2'b00, vsync, hsync};
        ch1_d    = 4'h0;
        ch2_d    = 4'h0;
        if (advance) begin
            ch0_d[3] = (cnt_d != 5'd0);
            ch0_d[2] = (cnt_d < HDR_ECC_FIRST) ? hdr_bit
                                               : hdr_ecc[cnt_d[2:0]];
            for (int k = 0; k < SUBPACKET_COUNT; k++) begin
                if (cnt_d < SP_ECC_FIRST) begin
                    ch1_d[k] = sp_bits[k][0];
                    ch2_d[k] = sp_bits[k][1];
                end else begin
                    ch1_d[k] = sp_ecc[k][{cnt_d[1:0], 1'b0}];
                    ch2_d[k] = sp_ecc[k][{cnt_d[1:0], 1'b1}];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            hdr_q    <= '0;
            sp_q     <= '0;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            ch0_q    <= 4'h0;
            ch1_q    <= 4'h0;
            ch2_q    <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hdr_q    <= hdr_d;
            sp_q     <= sp_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            ch0_q    <= ch0_d;
            ch1_q    <= ch1_d;
            ch2_q    <= ch2_d;
        end
    end

    assign pktReady     = ready_q;
    assign islandActive = active_q;
    assign ch0          = ch0_q;
    assign ch1          = ch1_q;
    assign ch2          = ch2_q;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Scoreboard bench for the data-island serializer: per-beat expectations
// come from a software BCH model and are popped as islandActive beats appear.
module tb_data_island_packet_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pktValid = 1'b0;
    logic        pktReady;
    logic [23:0] header = '0;
    logic [55:0] subpacket0 = '0;
    logic [55:0] subpacket1 = '0;
    logic [55:0] subpacket2 = '0;
    logic [55:0] subpacket3 = '0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        islandActive;
    logic [3:0]  ch0, ch1, ch2;

    data_island_packet_serializer dut (
        .clock       (clock),
        .reset       (reset),
        .pktValid    (pktValid),
        .pktReady    (pktReady),
        .header      (header),
        .subpacket0  (subpacket0),
        .subpacket1  (subpacket1),
        .subpacket2  (subpacket2),
        .subpacket3  (subpacket3),
        .hsync       (hsync),
        .vsync       (vsync),
        .islandActive(islandActive),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [1:0] c0hi;
        logic [3:0] c1;
        logic [3:0] c2;
        logic       rdy;
    } beat_t;

    beat_t sb[$];
    int total = 0;
    int bad = 0;
    int edges = 0;
    int run_len = 0;
    int last_run = 0;
    logic [1:0] sync_exp = 2'b00;
    logic [7:0] dut_hecc = '0;
    logic [7:0] dut_sp0ecc = '0;
    bit done = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_ecc(input logic [63:0] d, input int n);
        logic [7:0] e;
        logic fb;
        e = 8'h00;
        for (int b = 0; b < n; b++) begin
            fb = d[b] ^ e[0];
            e = {1'b0, e[7:1]};
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    task automatic push_pkt(input logic [23:0] h, input logic [55:0] s0,
                            input logic [55:0] s1, input logic [55:0] s2,
                            input logic [55:0] s3);
        logic [55:0] s[4];
        logic [7:0] he;
        logic [7:0] se[4];
        beat_t bt;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        he = ref_ecc({40'h0, h}, 24);
        for (int n = 0; n < 4; n++) se[n] = ref_ecc({8'h0, s[n]}, 56);
        for (int i = 0; i < 32; i++) begin
            bt.idx = i;
            bt.c0hi[1] = (i != 0);
            bt.c0hi[0] = (i < 24) ? h[i] : he[i-24];
            for (int n = 0; n < 4; n++) begin
                bt.c1[n] = (i < 28) ? s[n][2*i] : se[n][2*(i-28)];
                bt.c2[n] = (i < 28) ? s[n][2*i+1] : se[n][2*(i-28)+1];
            end
            bt.rdy = (i == 31);
            sb.push_back(bt);
        end
    endtask

    always @(posedge clock) begin
        sync_exp = reset ? 2'b00 : {vsync, hsync};
        edges = reset ? 0 : edges + 1;
    end

    always @(negedge clock) begin
        beat_t e;
        if (reset) begin
            chk("reset_out", {islandActive, pktReady, ch0, ch1, ch2}, 64'h0);
            run_len = 0;
        end else begin
            chk("sync", ch0[1:0], sync_exp);
            if (islandActive) begin
                run_len++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", islandActive, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ch0_hi", ch0[3:2], e.c0hi);
                    chk("ch1", ch1, e.c1);
                    chk("ch2", ch2, e.c2);
                    chk("ready_active", pktReady, e.rdy);
                    if (e.idx >= 24) dut_hecc[e.idx-24] = ch0[2];
                    if (e.idx >= 28) begin
                        dut_sp0ecc[2*(e.idx-28)] = ch1[0];
                        dut_sp0ecc[2*(e.idx-28)+1] = ch2[0];
                    end
                end
            end else begin
                chk("idle_ch", {ch0[3:2], ch1, ch2}, 64'h0);
                if (edges > 0) chk("idle_ready", pktReady, 1);
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        while (!done) begin
            @(posedge clock);
            #1 {vsync, hsync} = 2'($urandom_range(0, 3));
        end
    end

    task automatic send_pkt(input logic [23:0] h, input logic [55:0] s0,
                            input logic [55:0] s1, input logic [55:0] s2,
                            input logic [55:0] s3, input bit keep_valid);
        bit got;
        got = 0;
        header = h; subpacket0 = s0; subpacket1 = s1;
        subpacket2 = s2; subpacket3 = s3;
        pktValid = 1'b1;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clock);
            if (pktReady) begin
                push_pkt(h, s0, s1, s2, s3);
                got = 1;
            end
        end
        if (!got) chk("accept_timeout", pktReady, 1);
        @(posedge clock);
        #1;
        if (!keep_valid) pktValid = 1'b0;
        header = 24'($urandom());
        subpacket0 = 56'({$urandom(), $urandom()});
        subpacket1 = 56'({$urandom(), $urandom()});
        subpacket2 = 56'({$urandom(), $urandom()});
        subpacket3 = 56'({$urandom(), $urandom()});
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clock);
            if (sb.size() == 0 && !islandActive) ok = 1;
        end
        if (!ok) chk("drain_timeout", sb.size(), 0);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [55:0] rnd56();
        return 56'({$urandom(), $urandom()});
    endfunction

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        send_pkt(24'h0, 56'h0, 56'h0, 56'h0, 56'h0, 0);
        wait_idle();

        send_pkt(24'h000001, 56'h0, 56'h0, 56'h0, 56'h0, 0);
        wait_idle();
        chk("hdr_ecc_4a", dut_hecc, 8'h4A);

        send_pkt(24'h0, 56'h1, 56'h0, 56'h0, 56'h0, 0);
        wait_idle();
        chk("sp0_ecc", dut_sp0ecc, ref_ecc(64'h1, 56));

        send_pkt(24'($urandom()), rnd56(), rnd56(), rnd56(), rnd56(), 1);
        send_pkt(24'($urandom()), rnd56(), rnd56(), rnd56(), rnd56(), 1);
        send_pkt(24'($urandom()), rnd56(), rnd56(), rnd56(), rnd56(), 0);
        wait_idle();
        chk("run_96", last_run, 96);

        repeat (5) @(posedge clock);
        #1;
        send_pkt(24'($urandom()), rnd56(), rnd56(), rnd56(), rnd56(), 0);
        repeat (15) @(posedge clock);
        #2 reset = 1'b1;
        sb.delete();
        #1 chk("reset_async", {islandActive, ch0, ch1, ch2}, 64'h0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        send_pkt(24'($urandom()), rnd56(), rnd56(), rnd56(), rnd56(), 0);
        wait_idle();
        chk("run_32", last_run, 32);

        done = 1;
        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
